fifo_load_seq_tmr: RTL and testbench



---
 rtl/fifo_load_seq_tmr.sv | 148 ++++++++++++++
 tb/tb_fifo_load_seq_tmr.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_load_seq_tmr.sv
// Triple-redundant FIFO-load sequencer: walks SEL across NCHAN channels for each
// sample up to a latched SAMP_MAX, pulsing WRENA, with voted state and an upset counter.
module fifo_load_seq_tmr #(
    parameter int NCHAN  = 6,
    parameter int SEL_W  = 3,
    parameter int SAMP_W = 7,
    parameter int CNT_W  = 16,
    parameter int TMR    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [SAMP_W-1:0] SAMP_MAX,
    input  logic              CNT_CLR,
    output logic [SEL_W-1:0]  SEL,
    output logic              WRENA,
    output logic              BUSY,
    output logic              DONE,
    output logic              TMR_ERR,
    output logic [CNT_W-1:0]  TMR_ERR_COUNT
);
    localparam int REP_W = 2 + SEL_W + 2 + 2 * SAMP_W;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RST_SAMP = 2'd1;
    localparam logic [1:0] TRANSFER = 2'd2;
    localparam logic [1:0] NXT_SAMP = 2'd3;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCHAN - 1);

    // One replica holds {state, sel, wrena, done, sample, latched samp_max}.
    logic [REP_W-1:0]  rep_a, rep_b, rep_c, voted, nxt;
    logic [1:0]        v_state;
    logic [SEL_W-1:0]  v_sel;
    logic              v_wrena, v_done;
    logic [SAMP_W-1:0] v_sample, v_smax;

    logic [1:0]        n_state;
    logic [SEL_W-1:0]  n_sel;
    logic              n_wrena, n_done;
    logic [SAMP_W-1:0] n_sample, n_smax;

    assign {v_state, v_sel, v_wrena, v_done, v_sample, v_smax} = voted;

    always_comb begin
        n_state = IDLE;
        n_done  = 1'b0;
        case (v_state)
            IDLE:               n_state = (!ABORT && START) ? RST_SAMP : IDLE;
            RST_SAMP, NXT_SAMP: n_state = ABORT ? IDLE : TRANSFER;
            default: begin
                if (ABORT) begin
                    n_state = IDLE;
                end else if (START) begin
                    n_state = RST_SAMP;
                end else if (v_sel == LAST_SEL) begin
                    n_done  = (v_sample == v_smax);
                    n_state = n_done ? IDLE : NXT_SAMP;
                end else begin
                    n_state = TRANSFER;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        n_sel    = '0;
        n_wrena  = 1'b1;
        n_sample = v_sample;
        n_smax   = v_smax;
        case (n_state)
            IDLE: begin
                n_wrena  = 1'b0;
                n_sample = '0;
            end
            RST_SAMP: begin
                n_sample = '0;
                n_smax   = SAMP_MAX;
            end
            NXT_SAMP: n_sample = v_sample + SAMP_W'(1);
            default:  n_sel    = v_sel + SEL_W'(1);
        endcase
    end

    assign nxt = {n_state, n_sel, n_wrena, n_done, n_sample, n_smax};

    assign SEL   = v_sel;
    assign WRENA = v_wrena;
    assign DONE  = v_done;
    assign BUSY  = (v_state != IDLE);

    generate
        if (TMR != 0) begin : g_tmr
            logic             err;
            logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_v, cnt_nxt;

            assign voted = (rep_a & rep_b) | (rep_a & rep_c) | (rep_b & rep_c);
            assign err   = |((rep_a ^ rep_b) | (rep_a ^ rep_c));
            assign cnt_v = (cnt_a & cnt_b) | (cnt_a & cnt_c) | (cnt_b & cnt_c);

            always_comb begin
                cnt_nxt = cnt_v;
                if (CNT_CLR)
                    cnt_nxt = '0;
                else if (err && cnt_v != '1)
                    cnt_nxt = cnt_v + CNT_W'(1);
            end

            // Every replica reloads from the vote, so a single upset is scrubbed in one cycle.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    rep_a   <= '0;
                    rep_b   <= '0;
                    rep_c   <= '0;
                    cnt_a   <= '0;
                    cnt_b   <= '0;
                    cnt_c   <= '0;
                    TMR_ERR <= 1'b0;
                end else begin
                    rep_a   <= nxt;
                    rep_b   <= nxt;
                    rep_c   <= nxt;
                    cnt_a   <= cnt_nxt;
                    cnt_b   <= cnt_nxt;
                    cnt_c   <= cnt_nxt;
                    TMR_ERR <= err;
                end
            end

            assign TMR_ERR_COUNT = cnt_v;
        end else begin : g_single
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    rep_a <= '0;
                else
                    rep_a <= nxt;
            end

            assign rep_b         = '0;
            assign rep_c         = '0;
            assign voted         = rep_a;
            assign TMR_ERR       = 1'b0;
            assign TMR_ERR_COUNT = '0;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_load_seq_tmr.sv
// Randomised bench for fifo_load_seq_tmr: a TMR build and a single-copy build run in
// lockstep against a run-position model; replica upsets are injected with force.
module tb_fifo_load_seq_tmr;
    localparam int NCHAN   = 6;
    localparam int SEL_W   = 3;
    localparam int SAMP_W  = 7;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int REP_W   = 2 + SEL_W + 2 + 2 * SAMP_W;

    logic              clk = 1'b0;
    logic              rst, start, abort, cnt_clr;
    logic [SAMP_W-1:0] samp_max;

    logic [SEL_W-1:0]  sel_t, sel_s;
    logic              wrena_t, wrena_s, busy_t, busy_s, done_t, done_s, err_t, err_s;
    logic [CNT_W-1:0]  cnt_t, cnt_s;

    logic [REP_W-1:0]  flip_val, fix_val;

    int  total = 0;
    int  bad   = 0;
    int  cur_smax;

    // Model: a run is a position k over (smax+1)*NCHAN write cycles.
    bit  m_active, m_done, m_err;
    int  m_k, m_smax, m_cnt;

    fifo_load_seq_tmr #(.NCHAN(NCHAN), .SEL_W(SEL_W), .SAMP_W(SAMP_W), .CNT_W(CNT_W), .TMR(1)) dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .SAMP_MAX(samp_max), .CNT_CLR(cnt_clr),
        .SEL(sel_t), .WRENA(wrena_t), .BUSY(busy_t), .DONE(done_t), .TMR_ERR(err_t), .TMR_ERR_COUNT(cnt_t)
    );

    fifo_load_seq_tmr #(.NCHAN(NCHAN), .SEL_W(SEL_W), .SAMP_W(SAMP_W), .CNT_W(CNT_W), .TMR(0)) dut0 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .SAMP_MAX(samp_max), .CNT_CLR(cnt_clr),
        .SEL(sel_s), .WRENA(wrena_s), .BUSY(busy_s), .DONE(done_s), .TMR_ERR(err_s), .TMR_ERR_COUNT(cnt_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        int exp_sel;
        exp_sel = m_active ? (m_k % NCHAN) : 0;
        checkOutput("tmr_sel",   32'(sel_t),   32'(exp_sel));
        checkOutput("tmr_wrena", 32'(wrena_t), 32'(m_active));
        checkOutput("tmr_busy",  32'(busy_t),  32'(m_active));
        checkOutput("tmr_done",  32'(done_t),  32'(m_done));
        checkOutput("tmr_err",   32'(err_t),   32'(m_err));
        checkOutput("tmr_count", 32'(cnt_t),   32'(m_cnt));
        checkOutput("single_sel",   32'(sel_s),   32'(exp_sel));
        checkOutput("single_wrena", 32'(wrena_s), 32'(m_active));
        checkOutput("single_busy",  32'(busy_s),  32'(m_active));
        checkOutput("single_done",  32'(done_s),  32'(m_done));
        checkOutput("single_err",   32'(err_s),   32'(0));
        checkOutput("single_count", 32'(cnt_s),   32'(0));
    endtask

    // START is honoured from idle or mid-channel; at a sample boundary (channel 0) it is ignored.
    task automatic modelStep(input bit st, input bit ab, input bit clr, input bit inj, input int sm);
        m_done = 1'b0;
        if (ab) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (st && (!m_active || (m_k % NCHAN) != 0)) begin
            m_active = 1'b1;
            m_k      = 0;
            m_smax   = sm;
        end else if (m_active) begin
            if (m_k == (m_smax + 1) * NCHAN - 1) begin
                m_active = 1'b0;
                m_k      = 0;
                m_done   = 1'b1;
            end else begin
                m_k++;
            end
        end
        m_err = inj;
        if (clr)
            m_cnt = 0;
        else if (inj && m_cnt < CNT_MAX)
            m_cnt++;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input bit st, input bit ab, input bit clr, input bit inj, input int sm, input int flip_bit);
        start    = st;
        abort    = ab;
        cnt_clr  = clr;
        cur_smax = sm;
        samp_max = sm[SAMP_W-1:0];
        if (inj) begin
            flip_val = dut.rep_c ^ (REP_W'(1) << flip_bit);
            force dut.rep_c = flip_val;
        end
        @(posedge clk);
        modelStep(st, ab, clr, inj, sm);
        if (inj) begin
            #1;
            fix_val = dut.rep_a;
            force dut.rep_c = fix_val;
            #1;
            release dut.rep_c;
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, cur_smax, 0);
    endtask

    task automatic runUntil(input int target_k, input int budget);
        int n;
        n = 0;
        while (!(m_active && m_k == target_k) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget)
            checkOutput("wait_timeout", 32'(0), 32'(1));
    endtask

    task automatic runToIdle(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget)
            checkOutput("idle_timeout", 32'(0), 32'(1));
    endtask

    task automatic doReset();
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        cnt_clr = 1'b0;
        #2;
        m_active = 1'b0;
        m_k      = 0;
        m_smax   = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_cnt    = 0;
        checkAll();
        @(negedge clk);
        checkAll();
        rst = 1'b0;
    endtask

    initial begin
        int wr_cycles, done_cycles;
        samp_max = '0;
        cur_smax = 0;

        doReset();
        tick(4);

        // Two-sample-plus run with a single-cycle START.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
        wr_cycles = 1;
        done_cycles = 0;
        for (int i = 0; i < 21; i++) begin
            tick(1);
            if (wrena_t) wr_cycles++;
            if (done_t) done_cycles++;
        end
        checkOutput("run2_wrena_cycles", 32'(wr_cycles), 32'(18));
        checkOutput("run2_done_pulses", 32'(done_cycles), 32'(1));

        // SAMP_MAX changes after START must not affect the run.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        wr_cycles = 1;
        done_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
            if (wrena_t) wr_cycles++;
            if (done_t) done_cycles++;
        end
        checkOutput("latch_wrena_cycles", 32'(wr_cycles), 32'(6));
        checkOutput("latch_done_pulses", 32'(done_cycles), 32'(1));

        // Restart mid-transfer, then a START at a sample boundary that must be ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        runUntil(NCHAN + 3, 40);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        checkOutput("restart_sel", 32'(sel_t), 32'(0));
        runUntil(NCHAN, 40);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        runToIdle(40);
        tick(2);

        // ABORT with START in the same cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        runUntil(NCHAN + 2, 40);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
        checkOutput("abort_busy", 32'(busy_t), 32'(0));
        tick(3);

        // Single upset in the sample field of replica c, then repeated upsets to saturation.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
        runUntil(8, 40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5, SAMP_W);
        checkOutput("upset_count", 32'(cnt_t), 32'(1));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5, int'($urandom_range(0, REP_W - 1)));
            tick(1);
        end
        checkOutput("saturated_count", 32'(cnt_t), 32'(CNT_MAX));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5, 2);
        runToIdle(80);

        // Asynchronous reset in the middle of a run.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
        tick(5);
        doReset();
        tick(3);

        for (int i = 0; i < 900; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, REP_W - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
